regfile_access_arbiter: RTL and testbench
=========================================

REGFILE_ACCESS_ARBITER -- requirements
Module: regfile_access_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 5, register address width (32 registers).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0 / req1  input  1 each  access request from requester 0 (decode) / requester 1 (writeback).
REQ-006 ld_str0 / ld_str1  input  1 each  1 = load (read), 0 = store (write).
REQ-007 addr0 / addr1  input  ADDR_W each  target register.
REQ-008 wdata0 / wdata1  input  DATA_W each  store data.
REQ-009 ack0 / ack1  output  1 each  one-cycle pulse, request accepted and captured.
REQ-010 rvalid0 / rvalid1  output  1 each  one-cycle pulse, rdata holds load result for that requester.
REQ-011 rdata  output  DATA_W  shared load result, meaningful only with an rvalid pulse.
REQ-012 busy  output  1  high whenever FSM is not IDLE.
REQ-013 rf_en  output  1  register-file access strobe.
REQ-014 rf_ld_str  output  1  to register file: 1 = load, 0 = store.
REQ-015 rf_addr / rf_store_val  output  ADDR_W / DATA_W  register-file address and store data.
REQ-016 rf_load_val  input  DATA_W  register-file read data, valid the cycle after a load strobe.

Function
REQ-017 FSM states: IDLE, ISSUE, RD_WAIT; no other states are reachable.
REQ-018 IDLE with any req high: arbitrate, capture winner's ld_str/addr/wdata into internal registers, pulse that ack, go ISSUE next cycle.
REQ-019 Arbitration: round-robin with a 1-bit priority pointer (reset value 0); a sole requester always wins; on a tie the pointer side wins; after each grant the pointer moves to the non-granted requester.
REQ-020 ISSUE: rf_en=1, rf_ld_str/rf_addr/rf_store_val from captured fields; store goes IDLE next cycle, load goes RD_WAIT.
REQ-021 RD_WAIT: rdata=rf_load_val, rvalid of the granted requester pulses, go IDLE next cycle.
REQ-022 Latency from req sampled in IDLE: ack same cycle; store committed at end of ISSUE (cycle+1); load result at cycle+2; throughput 2 cycles per store, 3 per load.
REQ-023 Requester holds req and its fields until ack; req dropped before ack is a withdrawn request; req held after ack is a new request.
REQ-024 Requests arriving while busy are not acked until the FSM returns to IDLE.
REQ-025 Register 0: store with address 0 acked but rf_en stays 0 in ISSUE; load with address 0 returns rdata=0 in RD_WAIT regardless of rf_load_val.
REQ-026 Outside ISSUE: rf_en=0, rf_ld_str=1 (load idle, never an implied store); rdata=0 outside RD_WAIT.
REQ-027 At most one ack and at most one rvalid high per cycle.

Reset
REQ-028 Reset, including mid-ISSUE or mid-RD_WAIT: FSM to IDLE, pointer to 0, captured fields to 0, every output to 0 except rf_ld_str=1; aborted access produces no rvalid.
REQ-029 First ack possible in the first rising edge after reset deasserts.

Structure
REQ-030 A shared package holds the FSM state type, LD=1/ST=0 constants and the REG_ZERO address constant.
REQ-031 One sub-module, rr_arbiter2, implements the two-way round-robin pick and pointer update.

Verification
REQ-032 Reset then req1 store addr 5 data 0xDEADBEEF: ack1 same cycle, next cycle rf_en=1, rf_ld_str=0, rf_addr=5, rf_store_val=0xDEADBEEF.
REQ-033 req0 load addr 5, model returns 0xDEADBEEF: rvalid0 and rdata=0xDEADBEEF exactly 2 cycles after ack0.
REQ-034 req0 and req1 held high continuously from reset: grants alternate 0,1,0,1; no requester waits more than one access.
REQ-035 Store addr 0 data 0x1234 then load addr 0, model drives 0xFFFFFFFF: no rf_en during store, rdata=0 with rvalid.
REQ-036 Reset asserted in RD_WAIT: all outputs 0 immediately (rf_ld_str=1), no rvalid, next req0 acked after reset release.

Source files
------------

// File: rtl/regfile_access_arbiter_pkg.sv
// regfile_access_arbiter_pkg: shared FSM state type and access constants
package regfile_access_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;
  localparam logic LD = 1'b1;
  localparam logic ST = 1'b0;
  localparam int unsigned REG_ZERO = 0;
endpackage

// File: rtl/regfile_access_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick with a 1-bit priority pointer
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic ptr;
  assign gnt[0] = en & req[0] & (~req[1] | ~ptr);
  assign gnt[1] = en & req[1] & (~req[0] | ptr);
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr <= 1'b0;
    else if (gnt[0]) ptr <= 1'b1;
    else if (gnt[1]) ptr <= 1'b0;
endmodule

// File: rtl/regfile_access_arbiter.sv
// regfile_access_arbiter: two requesters sharing one register-file port
module regfile_access_arbiter
  import regfile_access_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              ld_str0,
  input  logic              ld_str1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              rf_en,
  output logic              rf_ld_str,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_store_val,
  input  logic [DATA_W-1:0] rf_load_val
);
  state_t state, state_nx;
  logic c_ld, c_who, zero, issue, rd_wait;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [1:0] gnt;
  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (state == IDLE && !reset),
    .req   ({req1, req0}),
    .gnt   (gnt)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      c_ld    <= 1'b0;
      c_who   <= 1'b0;
      c_addr  <= '0;
      c_wdata <= '0;
    end else begin
      state <= state_nx;
      if (|gnt) begin
        c_who   <= gnt[1];
        c_ld    <= gnt[1] ? ld_str1 : ld_str0;
        c_addr  <= gnt[1] ? addr1 : addr0;
        c_wdata <= gnt[1] ? wdata1 : wdata0;
      end
    end
  always_comb begin
    state_nx = IDLE;
    if (state == IDLE) state_nx = |gnt ? ISSUE : IDLE;
    else if (state == ISSUE) state_nx = c_ld == LD ? RD_WAIT : IDLE;
  end
  assign issue        = state == ISSUE;
  assign rd_wait      = state == RD_WAIT;
  assign zero         = c_addr == ADDR_W'(REG_ZERO);
  assign ack0         = gnt[0];
  assign ack1         = gnt[1];
  assign busy         = state != IDLE;
  // register 0 is hardwired: stores to it never reach the file
  assign rf_en        = issue & ~(c_ld == ST & zero);
  assign rf_ld_str    = issue ? c_ld : LD;
  assign rf_addr      = issue ? c_addr : '0;
  assign rf_store_val = issue ? c_wdata : '0;
  assign rdata        = rd_wait && !zero ? rf_load_val : '0;
  assign rvalid0      = rd_wait & ~c_who;
  assign rvalid1      = rd_wait & c_who;
endmodule

// File: tb/tb_regfile_access_arbiter.sv
// tb_regfile_access_arbiter: directed vector table plus reset/fairness sequences
module tb_regfile_access_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic req0 = 0, req1 = 0, ld_str0 = 0, ld_str1 = 0;
  logic [4:0] addr0 = 0, addr1 = 0, rf_addr;
  logic [31:0] wdata0 = 0, wdata1 = 0, rf_load_val = 0, rdata, rf_store_val;
  logic ack0, ack1, rvalid0, rvalid1, busy, rf_en, rf_ld_str;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  regfile_access_arbiter dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .ld_str0(ld_str0), .ld_str1(ld_str1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .ack0(ack0), .ack1(ack1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata), .busy(busy),
    .rf_en(rf_en), .rf_ld_str(rf_ld_str), .rf_addr(rf_addr),
    .rf_store_val(rf_store_val), .rf_load_val(rf_load_val)
  );

  typedef struct {
    logic r0, r1, l0, l1;
    logic [4:0] a0, a1;
    logic [31:0] w0, w1, lv;
    logic ak0, ak1, rv0, rv1, bz, en, ld;
    logic [4:0] ra;
    logic [31:0] sv, rd;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ak0, ak1, rv0, rv1, bz, en, ld,
                         input logic [4:0] ra, input logic [31:0] sv, rd);
    chk({tag, " ack0"}, 32'(ack0), 32'(ak0));
    chk({tag, " ack1"}, 32'(ack1), 32'(ak1));
    chk({tag, " rvalid0"}, 32'(rvalid0), 32'(rv0));
    chk({tag, " rvalid1"}, 32'(rvalid1), 32'(rv1));
    chk({tag, " busy"}, 32'(busy), 32'(bz));
    chk({tag, " rf_en"}, 32'(rf_en), 32'(en));
    chk({tag, " rf_ld_str"}, 32'(rf_ld_str), 32'(ld));
    chk({tag, " rf_addr"}, 32'(rf_addr), 32'(ra));
    chk({tag, " rf_store_val"}, rf_store_val, sv);
    chk({tag, " rdata"}, rdata, rd);
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; ld_str0 = 0; ld_str1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; rf_load_val = 0;
  endtask

  initial begin
    //          r0 r1 l0 l1 a0 a1 w0     w1            lv            ak0 ak1 rv0 rv1 bz en ld ra sv            rd
    tbl[0]  = '{0, 1, 0, 0, 0, 5, 0,     32'hDEADBEEF, 0,            0, 1, 0, 0, 0, 0, 1, 0, 0,            0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0,     0,            0,            0, 0, 0, 0, 1, 1, 0, 5, 32'hDEADBEEF, 0};
    tbl[2]  = '{1, 0, 1, 0, 5, 0, 0,     0,            0,            1, 0, 0, 0, 0, 0, 1, 0, 0,            0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0,     0,            0,            0, 0, 0, 0, 1, 1, 1, 5, 0,            0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0,     0,            32'hDEADBEEF, 0, 0, 1, 0, 1, 0, 1, 0, 0,            32'hDEADBEEF};
    tbl[5]  = '{1, 0, 0, 0, 0, 0, 32'h1234, 0,         0,            1, 0, 0, 0, 0, 0, 1, 0, 0,            0};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0,     0,            0,            0, 0, 0, 0, 1, 0, 0, 0, 32'h1234,     0};
    tbl[7]  = '{0, 1, 0, 1, 0, 0, 0,     0,            0,            0, 1, 0, 0, 0, 0, 1, 0, 0,            0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0,     0,            0,            0, 0, 0, 0, 1, 1, 1, 0, 0,            0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0,     0,            32'hFFFFFFFF, 0, 0, 0, 1, 1, 0, 1, 0, 0,            0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0,     0,            32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 1, 0, 0,            0};
    tbl[11] = '{1, 1, 0, 0, 3, 4, 32'hA, 32'hB,        0,            1, 0, 0, 0, 0, 0, 1, 0, 0,            0};
    tbl[12] = '{1, 1, 0, 0, 3, 4, 32'hA, 32'hB,        0,            0, 0, 0, 0, 1, 1, 0, 3, 32'hA,        0};
    tbl[13] = '{1, 1, 0, 0, 3, 4, 32'hA, 32'hB,        0,            0, 1, 0, 0, 0, 0, 1, 0, 0,            0};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 0,     0,            0,            0, 0, 0, 0, 1, 1, 0, 4, 32'hB,        0};

    repeat (2) @(negedge clk);
    #1 chk_all("reset", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 15; i++) begin
      req0 = tbl[i].r0; req1 = tbl[i].r1; ld_str0 = tbl[i].l0; ld_str1 = tbl[i].l1;
      addr0 = tbl[i].a0; addr1 = tbl[i].a1; wdata0 = tbl[i].w0; wdata1 = tbl[i].w1;
      rf_load_val = tbl[i].lv;
      #1 chk_all($sformatf("vec%0d", i), tbl[i].ak0, tbl[i].ak1, tbl[i].rv0, tbl[i].rv1,
                 tbl[i].bz, tbl[i].en, tbl[i].ld, tbl[i].ra, tbl[i].sv, tbl[i].rd);
      @(negedge clk);
    end

    // both requesters held from reset: grants must alternate every store slot
    idle_inputs();
    reset = 1;
    @(negedge clk);
    req0 = 1; req1 = 1; addr0 = 1; addr1 = 2; wdata0 = 32'h11; wdata1 = 32'h22;
    @(negedge clk);
    reset = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("fair%0d ack0", k), 32'(ack0), 32'(k % 4 == 0));
      chk($sformatf("fair%0d ack1", k), 32'(ack1), 32'(k % 4 == 2));
      if (k % 2 == 1) chk($sformatf("fair%0d rf_addr", k), 32'(rf_addr), (k % 4 == 1) ? 32'd1 : 32'd2);
      @(negedge clk);
    end

    // reset during RD_WAIT aborts the load without an rvalid
    idle_inputs();
    reset = 1;
    @(negedge clk);
    reset = 0;
    req0 = 1; ld_str0 = 1; addr0 = 3;
    #1 chk("abort ack0", 32'(ack0), 1);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rf_load_val = 32'hCAFEF00D;
    #1 chk("abort pre rvalid0", 32'(rvalid0), 1);
    reset = 1;
    #1 chk_all("abort in reset", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    #1 chk_all("abort held", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    reset = 0;
    rf_load_val = 0;
    req0 = 1; ld_str0 = 0; addr0 = 7; wdata0 = 32'h77;
    #1 chk("post reset ack0", 32'(ack0), 1);
    @(negedge clk);
    idle_inputs();
    #1 chk_all("post reset issue", 0, 0, 0, 0, 1, 1, 0, 7, 32'h77, 0);
    @(negedge clk);
    #1 chk_all("post reset idle", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
